// File: rtl/spi_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | spi_ctrl_pkg: state encoding and byte-size constant for spi_ctrl.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  localparam logic [3:0] BIT_COUNT = 4'd8;

endpackage

`default_nettype wire

// File: rtl/spi_ctrl_clkdiv.sv
// +--------------------------------------------------------------------+
// | spi_ctrl_clkdiv: loadable half-period down-counter, tick at zero.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module spi_ctrl_clkdiv #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_val,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/spi_ctrl_core.sv
// +--------------------------------------------------------------------+
// | spi_ctrl_core: byte-oriented SPI master with programmable SCK.     |
// | SPI_CTRL_MODE_EN adds cpol/cpha inputs. Revision: 1.0              |
// +--------------------------------------------------------------------+
`default_nettype none

module spi_ctrl_core
  import spi_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef SPI_CTRL_MODE_EN
  input  logic                 cpol,
  input  logic                 cpha,
`endif
  output logic                 spi_sck,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  output logic                 spi_cs_n,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [7:0]           user_in,
  input  logic                 user_in_last,
  input  logic                 user_in_valid,
  output logic                 user_in_ack,
  output logic [7:0]           user_out,
  output logic                 user_out_stb,
  output logic                 busy
);

  state_t               state_q, state_d;
  logic [7:0]           tx_q, tx_d;
  logic [7:0]           rx_q, rx_d;
  logic [7:0]           user_out_q, user_out_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 mosi_q, mosi_d;
  logic                 sck_q, sck_d;
  logic                 cs_n_q, cs_n_d;
  logic                 last_q, last_d;
  logic                 ack_q;
  logic                 stb_pend_q, stb_pend_d;
  logic                 stb_q;

  logic                 accept;
  logic                 phase_load;
  logic                 sample;
  logic                 update;
  logic                 tick;
  logic                 cpha_now;

`ifdef SPI_CTRL_MODE_EN
  logic cpol_q, cpol_d;
  logic cpha_q, cpha_d;

  // Mode is taken from the inputs while idle so the pins already show the requested idle level.
  assign cpha_now = (state_q == ST_IDLE) ? cpha : cpha_q;
  assign spi_sck  = sck_q ^ ((state_q == ST_IDLE) ? cpol : cpol_q);
`else
  assign cpha_now = 1'b0;
  assign spi_sck  = sck_q;
`endif

  spi_ctrl_clkdiv #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clkdiv (
    .clk      (clk),
    .rst      (rst),
    .load     (accept | phase_load),
    .load_val (accept ? div : div_q),
    .tick     (tick)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    user_out_d = user_out_q;
    bit_cnt_d  = bit_cnt_q;
    div_d      = div_q;
    mosi_d     = mosi_q;
    sck_d      = sck_q;
    cs_n_d     = cs_n_q;
    last_d     = last_q;
    stb_pend_d = 1'b0;
    accept     = 1'b0;
    phase_load = 1'b0;
    sample     = 1'b0;
    update     = 1'b0;
`ifdef SPI_CTRL_MODE_EN
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (user_in_valid && !ack_q) begin
          accept  = 1'b1;
          cs_n_d  = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          phase_load = 1'b1;
          sck_d      = 1'b1;
          bit_cnt_d  = 4'd1;
          state_d    = ST_SHIFT;
          if (cpha_now) update = 1'b1;
          else          sample = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          phase_load = 1'b1;
          if (sck_q) begin
            sck_d = 1'b0;
            if (cpha_now)                      sample = 1'b1;
            else if (bit_cnt_q != BIT_COUNT)   update = 1'b1;
          end else if (bit_cnt_q != BIT_COUNT) begin
            sck_d     = 1'b1;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (cpha_now) update = 1'b1;
            else          sample = 1'b1;
          end else begin
            // Closing low phase of the byte: report it and chain straight into the next one if offered.
            user_out_d = rx_q;
            stb_pend_d = 1'b1;
            if (last_q) begin
              state_d = ST_HOLD;
            end else if (user_in_valid && !ack_q) begin
              accept    = 1'b1;
              sck_d     = 1'b1;
              bit_cnt_d = 4'd1;
              if (!cpha_now) sample = 1'b1;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        if (user_in_valid && !ack_q) begin
          accept  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_HOLD: begin
        if (tick) begin
          phase_load = 1'b1;
          cs_n_d     = 1'b1;
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (sample) begin
      rx_d = {rx_q[6:0], spi_miso};
    end
    if (update) begin
      mosi_d = tx_q[7];
      tx_d   = {tx_q[6:0], 1'b0};
    end
    if (accept) begin
      last_d = user_in_last;
      div_d  = div;
      // With cpha=1 a byte entering SETUP waits for the first leading edge to present bit 7.
      if ((state_q == ST_SHIFT) || !cpha_now) begin
        mosi_d = user_in[7];
        tx_d   = {user_in[6:0], 1'b0};
      end else begin
        tx_d   = user_in;
      end
`ifdef SPI_CTRL_MODE_EN
      if (state_q == ST_IDLE) begin
        cpol_d = cpol;
        cpha_d = cpha;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_q       <= 8'h00;
      rx_q       <= 8'h00;
      user_out_q <= 8'h00;
      bit_cnt_q  <= 4'd0;
      div_q      <= '0;
      mosi_q     <= 1'b0;
      sck_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      last_q     <= 1'b0;
      ack_q      <= 1'b0;
      stb_pend_q <= 1'b0;
      stb_q      <= 1'b0;
`ifdef SPI_CTRL_MODE_EN
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      user_out_q <= user_out_d;
      bit_cnt_q  <= bit_cnt_d;
      div_q      <= div_d;
      mosi_q     <= mosi_d;
      sck_q      <= sck_d;
      cs_n_q     <= cs_n_d;
      last_q     <= last_d;
      ack_q      <= accept;
      stb_pend_q <= stb_pend_d;
      stb_q      <= stb_pend_q;
`ifdef SPI_CTRL_MODE_EN
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
`endif
    end
  end

  assign spi_mosi     = mosi_q;
  assign spi_cs_n     = cs_n_q;
  assign user_in_ack  = ack_q;
  assign user_out     = user_out_q;
  assign user_out_stb = stb_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_ctrl_core.sv
// +--------------------------------------------------------------------+
// | tb_spi_ctrl_core: directed bench for spi_ctrl_core.                |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_spi_ctrl_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       spi_sck, spi_mosi, spi_miso, spi_cs_n;
  logic [7:0] div_in = 8'd0;
  logic [7:0] user_in = 8'd0;
  logic       user_in_last = 1'b0;
  logic       user_in_valid = 1'b0;
  logic       user_in_ack;
  logic [7:0] user_out;
  logic       user_out_stb;
  logic       busy;
`ifdef SPI_CTRL_MODE_EN
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
`endif

  spi_ctrl_core #(
    .DIV_WIDTH (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef SPI_CTRL_MODE_EN
    .cpol          (cpol),
    .cpha          (cpha),
`endif
    .spi_sck       (spi_sck),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .spi_cs_n      (spi_cs_n),
    .div           (div_in),
    .user_in       (user_in),
    .user_in_last  (user_in_last),
    .user_in_valid (user_in_valid),
    .user_in_ack   (user_in_ack),
    .user_out      (user_out),
    .user_out_stb  (user_out_stb),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // Monitors only ever count up; tests work from snapshots of them.
  int ack_cnt = 0, stb_cnt = 0, cs_low = 0, gap_cyc = 0, cs_rise = 0;
  int rise_cnt = 0, fall_cnt = 0;
  int ack_t [0:63];
  int stb_t [0:63];
  logic [7:0] stb_v [0:63];
  logic mosi_at [0:255];

  always @(negedge clk) begin
    if (user_in_ack === 1'b1) begin
      ack_t[ack_cnt % 64] = cyc;
      ack_cnt++;
    end
    if (user_out_stb === 1'b1) begin
      stb_t[stb_cnt % 64] = cyc;
      stb_v[stb_cnt % 64] = user_out;
      stb_cnt++;
    end
    if (spi_cs_n === 1'b0) cs_low++;
    if (spi_cs_n === 1'b1 && busy === 1'b1) gap_cyc++;
  end

  always @(posedge spi_cs_n) cs_rise++;
  always @(posedge spi_sck) begin
    mosi_at[rise_cnt % 256] = spi_mosi;
    rise_cnt++;
  end
  always @(negedge spi_sck) fall_cnt++;

  // Mode-0 peer: shifts its next bit out after every falling SCK edge.
  logic       loopback = 1'b1;
  int         fall_base = 0;
  int         f_rel;
  logic [7:0] peer_bytes [0:3];
  logic [7:0] peer_cur;
  logic       peer_bit;
  always_comb begin
    f_rel    = fall_cnt - fall_base;
    peer_cur = peer_bytes[(f_rel / 8) % 4];
    peer_bit = peer_cur[3'(7 - (f_rel % 8))];
  end
  assign spi_miso = loopback ? spi_mosi : peer_bit;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // sel: 0 = ack pulse, 1 = busy low, 2 = stb pulse
  task automatic wait_for(input string tag, input int sel, input int budget);
    int got;
    got = 0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk);
      #3;
      if ((sel == 0 && user_in_ack === 1'b1) || (sel == 1 && busy === 1'b0) ||
          (sel == 2 && user_out_stb === 1'b1)) begin
        got = 1;
        break;
      end
    end
    check(tag, got, 1);
  endtask

  task automatic send(input logic [7:0] b, input logic last, input logic [7:0] d);
    user_in       = b;
    user_in_last  = last;
    div_in        = d;
    user_in_valid = 1'b1;
  endtask

  int a0, s0, r0, cl0, g0, cr0, bad_wait;
  logic [7:0] mbyte;

  initial begin
    peer_bytes[0] = 8'h00; peer_bytes[1] = 8'h00;
    peer_bytes[2] = 8'h00; peer_bytes[3] = 8'h00;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("rst_cs_n", int'(spi_cs_n), 1);
    check("rst_sck", int'(spi_sck), 0);
    check("rst_mosi", int'(spi_mosi), 0);
    check("rst_ack", int'(user_in_ack), 0);
    check("rst_stb", int'(user_out_stb), 0);
    check("rst_user_out", int'(user_out), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #3;

    // div=0 loopback, single byte with last
    a0 = ack_cnt; s0 = stb_cnt; r0 = rise_cnt; cl0 = cs_low; g0 = gap_cyc;
    loopback = 1'b1;
    send(8'hA5, 1'b1, 8'd0);
    wait_for("t1_ack_wait", 0, 20);
    user_in_valid = 1'b0;
    wait_for("t1_idle_wait", 1, 100);
    repeat (3) @(posedge clk);
    #3;
    check("t1_ack_count", ack_cnt - a0, 1);
    check("t1_stb_count", stb_cnt - s0, 1);
    check("t1_user_out", int'(stb_v[s0 % 64]), 'hA5);
    check("t1_latency", stb_t[s0 % 64] - ack_t[a0 % 64], 18);
    check("t1_sck_rises", rise_cnt - r0, 8);
    check("t1_cs_low_cycles", cs_low - cl0, 18);
    check("t1_gap_cycles", gap_cyc - g0, 1);

    // div=3 back-to-back, valid held, peer answers 0x81 then 0x7E
    a0 = ack_cnt; s0 = stb_cnt; r0 = rise_cnt; cr0 = cs_rise;
    loopback = 1'b0;
    peer_bytes[0] = 8'h81; peer_bytes[1] = 8'h7E;
    fall_base = fall_cnt;
    send(8'h3C, 1'b0, 8'd3);
    wait_for("t2_ack1_wait", 0, 20);
    user_in      = 8'hC3;
    user_in_last = 1'b1;
    wait_for("t2_ack2_wait", 0, 200);
    user_in_valid = 1'b0;
    wait_for("t2_idle_wait", 1, 200);
    repeat (3) @(posedge clk);
    #3;
    check("t2_ack_count", ack_cnt - a0, 2);
    check("t2_cs_rises", cs_rise - cr0, 1);
    check("t2_stb_count", stb_cnt - s0, 2);
    check("t2_rx_byte0", int'(stb_v[s0 % 64]), 'h81);
    check("t2_rx_byte1", int'(stb_v[(s0 + 1) % 64]), 'h7E);
    check("t2_ack_spacing", ack_t[(a0 + 1) % 64] - ack_t[a0 % 64], 68);
    check("t2_latency0", stb_t[s0 % 64] - ack_t[a0 % 64], 69);
    check("t2_latency1_no_setup", stb_t[(s0 + 1) % 64] - ack_t[(a0 + 1) % 64], 65);
    check("t2_sck_rises", rise_cnt - r0, 16);
    for (int i = 0; i < 8; i++) mbyte[7 - i] = mosi_at[(r0 + i) % 256];
    check("t2_mosi_byte0", int'(mbyte), 'h3C);

    // WAIT: drop valid after a non-last byte, then resume
    a0 = ack_cnt; s0 = stb_cnt; cr0 = cs_rise;
    loopback = 1'b1;
    send(8'h96, 1'b0, 8'd1);
    wait_for("t3_ack1_wait", 0, 20);
    user_in_valid = 1'b0;
    wait_for("t3_stb1_wait", 2, 100);
    check("t3_rx_byte0", int'(user_out), 'h96);
    bad_wait = 0;
    repeat (50) begin
      @(posedge clk);
      #3;
      if (spi_cs_n !== 1'b0 || spi_sck !== 1'b0 || busy !== 1'b1) bad_wait++;
    end
    check("t3_wait_held_cycles_bad", bad_wait, 0);
    check("t3_cs_rises_in_wait", cs_rise - cr0, 0);
    send(8'h69, 1'b1, 8'd1);
    wait_for("t3_ack2_wait", 0, 20);
    user_in_valid = 1'b0;
    wait_for("t3_idle_wait", 1, 100);
    repeat (3) @(posedge clk);
    #3;
    check("t3_latency_with_setup", stb_t[(s0 + 1) % 64] - ack_t[(a0 + 1) % 64], 35);
    check("t3_rx_byte1", int'(user_out), 'h69);
    check("t3_cs_rises", cs_rise - cr0, 1);

    // Asynchronous reset inside the 4th SCK high phase
    s0 = stb_cnt; r0 = rise_cnt;
    send(8'hFF, 1'b1, 8'd2);
    wait_for("t4_ack_wait", 0, 20);
    user_in_valid = 1'b0;
    bad_wait = 1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #3;
      if (rise_cnt - r0 == 4) begin
        bad_wait = 0;
        break;
      end
    end
    check("t4_reach_4th_high", bad_wait, 0);
    #1 rst = 1'b1;
    #1;
    check("t4_rst_cs_n", int'(spi_cs_n), 1);
    check("t4_rst_sck", int'(spi_sck), 0);
    check("t4_rst_mosi", int'(spi_mosi), 0);
    check("t4_rst_busy", int'(busy), 0);
    check("t4_rst_user_out", int'(user_out), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    check("t4_no_partial_stb", stb_cnt - s0, 0);
    send(8'h5C, 1'b1, 8'd0);
    wait_for("t4_ack_clean_wait", 0, 20);
    user_in_valid = 1'b0;
    wait_for("t4_idle_wait", 1, 100);
    repeat (3) @(posedge clk);
    #3;
    check("t4_clean_stb_count", stb_cnt - s0, 1);
    check("t4_clean_user_out", int'(user_out), 'h5C);

    // div changed from 1 to 7 mid-byte affects only the next byte
    a0 = ack_cnt; s0 = stb_cnt;
    send(8'h10, 1'b0, 8'd1);
    wait_for("t5_ack1_wait", 0, 20);
    user_in      = 8'h22;
    user_in_last = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    div_in = 8'd7;
    wait_for("t5_ack2_wait", 0, 200);
    user_in_valid = 1'b0;
    wait_for("t5_idle_wait", 1, 400);
    repeat (3) @(posedge clk);
    #3;
    check("t5_ack_spacing_T2", ack_t[(a0 + 1) % 64] - ack_t[a0 % 64], 34);
    check("t5_latency0_T2", stb_t[s0 % 64] - ack_t[a0 % 64], 35);
    check("t5_latency1_T8", stb_t[(s0 + 1) % 64] - ack_t[(a0 + 1) % 64], 129);
    check("t5_rx_byte0", int'(stb_v[s0 % 64]), 'h10);
    check("t5_rx_byte1", int'(stb_v[(s0 + 1) % 64]), 'h22);

`ifdef SPI_CTRL_MODE_EN
    // cpol=1 cpha=1 loopback
    s0 = stb_cnt;
    cpol = 1'b1;
    cpha = 1'b1;
    @(posedge clk);
    #3;
    check("m_sck_idle_high_before", int'(spi_sck), 1);
    send(8'h5A, 1'b1, 8'd1);
    wait_for("m_ack_wait", 0, 20);
    user_in_valid = 1'b0;
    wait_for("m_idle_wait", 1, 100);
    repeat (3) @(posedge clk);
    #3;
    check("m_sck_idle_high_after", int'(spi_sck), 1);
    check("m_stb_count", stb_cnt - s0, 1);
    check("m_user_out", int'(user_out), 'h5A);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
